light_mode_ctrl: RTL and testbench
==================================

// Module: light_mode_ctrl
// PURPOSE
//   Drive side of the light-stand 4x1 select mux: generates the 3-bit select code and the four
//   PWM brightness channels that the mux consumes. A debounced push-button steps the mode
//   OFF -> L1 -> L2 -> L3 -> L4 -> OFF. o_sel/o_pwm connect directly to the mux i_sel/i_a.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  consecutive cycles of a changed synced level before it is accepted (>=2)
//   PWM_PERIOD       100        PWM counter period in clocks (>=4)
// PORTS
//   i_clk    in   1  system clock; single clock domain
//   i_reset  in   1  synchronous, active-high reset
//   i_btn    in   1  raw asynchronous push-button, high = pressed
//   o_sel    out  3  mode / mux select: 000 OFF, 001 L1, 010 L2, 011 L3, 100 L4
//   o_pwm    out  4  PWM channels; o_pwm[k] has duty (k+1)/4; feeds mux i_a[k]
// BEHAVIOUR
//   Reset: every flop is cleared on i_clk while i_reset=1. This covers the sync stages,
//     debounce counter, debounced level, PWM counter and state (=OFF). o_sel=000, o_pwm=0000.
//   Synchroniser: 2-FF chain on i_btn. The second stage is the "synced" level.
//   Debounce: 32-bit-max counter dcnt.
//     - Synced == debounced level: dcnt <= 0.
//     - Synced differs and dcnt == DEBOUNCE_CYCLES-1: debounced <= synced, dcnt <= 0.
//     - Synced differs otherwise: dcnt++.
//     - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
//   Press pulse: debounced & ~debounced_q, one cycle wide. Release generates nothing.
//   FSM: state is 3 bits and o_sel = state (registered, no combinational path).
//     - press in OFF->L1, L1->L2, L2->L3, L3->L4, L4->OFF. No press: hold.
//     - Illegal codes 101..111 -> OFF on the next edge, regardless of press.
//   Latency: with edge 1 the first edge that samples i_btn=1 (held clean), o_sel
//     updates on edge DEBOUNCE_CYCLES+3.
//   PWM: pcnt counts 0..PWM_PERIOD-1, then wraps to 0. It free-runs, independent of state.
//     - Duty threshold D_k = (PWM_PERIOD*(k+1))/4, integer floor.
//     - o_pwm[k] <= (pcnt < D_k), registered, so the output lags pcnt by one cycle.
//     - o_pwm[3] is constant 1 after the first post-reset edge (100% duty).
//     - Outputs run in every state; OFF blanking is the mux's job (sel 000 -> 0).
//   Boundaries:
//     - Reset mid-debounce or mid-press: count is lost and state returns to OFF.
//     - Button held through reset release: the debounced level rises DEBOUNCE_CYCLES after
//       reset and counts as one press (OFF->L1). This is required and deterministic.
//     - Held button gives exactly one advance. Next advance needs a debounced release, then a press.
//     - Press exactly at L4 wraps to OFF. No saturation.
//     - pcnt wrap and press in the same cycle are independent. No interaction.
// STRUCTURE
//   Package light_stand_pkg:
//     - localparams S_OFF=3'd0, S_L1..S_L4=3'd1..3'd4, shared with the mux select decode.
//     - NUM_CH=4.
//   Sub-module btn_debounce (DEBOUNCE_CYCLES): i_clk, i_reset, i_btn -> o_level, o_press.
//     Contains the synchroniser, counter and edge detect.
//   The top holds the mode FSM and the PWM counter/comparators.
// TESTING (bench uses DEBOUNCE_CYCLES=4, PWM_PERIOD=8)
//   1 Reset then idle 20 cycles -> o_sel=000 throughout. After the first edge o_pwm[3]=1;
//     o_pwm[0] is high 2 of every 8 cycles, [1] 4/8, [2] 6/8.
//   2 Clean press held 30 cycles, first sampled at edge 1 -> o_sel 000->001 exactly at edge 7.
//     No further change while held.
//   3 Five clean press/release pairs (each level held 10 cycles) -> o_sel steps
//     001,010,011,100,000.
//   4 Bounce: i_btn 1 for 3 cycles, 0 for 2, repeated 5 times, then 0 -> o_sel unchanged.
//   5 i_reset asserted 1 cycle while o_sel=011 and mid-debounce -> next cycle o_sel=000,
//     o_pwm=0000, no stray advance after release.
//   6 i_btn=1 held across reset deassert -> o_sel=001 after DEBOUNCE_CYCLES+3 edges,
//     then stays 001.

Source files
------------

// File: rtl/light_stand_pkg.sv
// Shared constants for the light stand: mode/select codes, channel count and PWM duty helper.
package light_stand_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned NUM_CH = 4;

    // Mode codes double as the mux select decode.
    localparam logic [SEL_W-1:0] S_OFF = 3'd0;
    localparam logic [SEL_W-1:0] S_L1  = 3'd1;
    localparam logic [SEL_W-1:0] S_L2  = 3'd2;
    localparam logic [SEL_W-1:0] S_L3  = 3'd3;
    localparam logic [SEL_W-1:0] S_L4  = 3'd4;

    // Duty threshold for channel k: floor(period*(k+1)/4) counts high per period.
    function automatic int unsigned duty_threshold(input int unsigned period,
                                                   input int unsigned k);
        return (period * (k + 32'd1)) / 32'd4;
    endfunction

endpackage

// File: rtl/light_mode_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, counter-based debounce and press-edge detect.
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   i_btn    raw asynchronous button, high = pressed
//   o_level  debounced button level (registered)
//   o_press  one-cycle pulse on a debounced rising edge (combinational from flops)
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CNT_W = 32;

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] dcnt;

    // Synchroniser, debounce counter and delayed level for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            o_level <= 1'b0;
            level_q <= 1'b0;
            dcnt    <= '0;
        end else begin
            sync1   <= i_btn;
            sync2   <= sync1;
            level_q <= o_level;
            if (sync2 == o_level) begin
                dcnt <= '0;
            end else if (dcnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                o_level <= sync2;
                dcnt    <= '0;
            end else begin
                dcnt <= dcnt + CNT_W'(1);
            end
        end
    end

    // Derived purely from flops; registering it would add a cycle of press latency.
    assign o_press = o_level & ~level_q;

endmodule

// File: rtl/light_mode_ctrl.sv
// Light-stand mode controller: debounced button steps OFF->L1..L4->OFF, plus four
// free-running PWM channels with duty (k+1)/4 feeding the select mux.
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   i_btn    raw asynchronous button, high = pressed
//   o_sel    registered mode / mux select (000 OFF .. 100 L4)
//   o_pwm    registered PWM channels, o_pwm[k] duty (k+1)/4
module light_mode_ctrl
    import light_stand_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned PWM_PERIOD      = 100
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_btn,
    output logic [SEL_W-1:0]  o_sel,
    output logic [NUM_CH-1:0] o_pwm
);

    localparam int unsigned PCNT_W = $clog2(PWM_PERIOD);

    logic              press;
    logic [PCNT_W-1:0] pcnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn),
        .o_level (),
        .o_press (press)
    );

    // Mode FSM; the state register is the select output, illegal codes recover to OFF.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_sel <= S_OFF;
        end else begin
            case (o_sel)
                S_OFF:   if (press) o_sel <= S_L1;
                S_L1:    if (press) o_sel <= S_L2;
                S_L2:    if (press) o_sel <= S_L3;
                S_L3:    if (press) o_sel <= S_L4;
                S_L4:    if (press) o_sel <= S_OFF;
                default: o_sel <= S_OFF;
            endcase
        end
    end

    // Free-running PWM counter and registered duty comparators.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pcnt  <= '0;
            o_pwm <= '0;
        end else begin
            if (pcnt == PCNT_W'(PWM_PERIOD - 1)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PCNT_W'(1);
            end
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                o_pwm[k] <= (32'(pcnt) < duty_threshold(PWM_PERIOD, k));
            end
        end
    end

endmodule

// File: tb/tb_light_mode_ctrl.sv
// Self-checking bench for light_mode_ctrl: directed scenarios plus randomized button
// activity, all compared cycle by cycle against a behavioural model.
module tb_light_mode_ctrl;

    localparam int unsigned DC = 4;
    localparam int unsigned PP = 8;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_btn;
    logic [2:0] o_sel;
    logic [3:0] o_pwm;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_s1, m_s2, m_deb, m_deb_prev, m_run, m_mode, m_pcnt, m_pwm;

    light_mode_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .PWM_PERIOD     (PP)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn),
        .o_sel   (o_sel),
        .o_pwm   (o_pwm)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the model: button passes two sync stages, must disagree with the
    // debounced level for DC consecutive edges to flip it, a rising debounced level is
    // one press, and the mode is a 5-position ring stepped by presses.
    task automatic model_step(input int b, input int r);
        bit press;
        if (r != 0) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_prev = 0; m_run = 0;
            m_mode = 0; m_pcnt = 0; m_pwm = 0;
        end else begin
            press = (m_deb == 1) && (m_deb_prev == 0);
            if (press) m_mode = (m_mode + 1) % 5;
            m_deb_prev = m_deb;
            m_pwm = 0;
            for (int k = 0; k < 4; k++)
                if (m_pcnt < (PP * (k + 1)) / 4) m_pwm = m_pwm | (1 << k);
            m_pcnt = (m_pcnt + 1) % PP;
            if (m_s2 != m_deb) begin
                m_run++;
                if (m_run == DC) begin
                    m_deb = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic tick(input logic b, input logic r);
        i_btn   = b;
        i_reset = r;
        @(posedge i_clk);
        model_step(int'(b), int'(r));
        #1;
        check("sel_model", int'(o_sel), m_mode);
        check("pwm_model", int'(o_pwm), m_pwm);
    endtask

    task automatic press_release(input int len);
        for (int i = 0; i < len; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < len; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        int cnt[4];
        int exp3[5];
        exp3 = '{1, 2, 3, 4, 0};
        i_reset = 1'b1;
        i_btn   = 1'b0;

        // 1: reset, idle, PWM duty over two full periods
        tick(1'b0, 1'b1);
        check("reset_sel", int'(o_sel), 0);
        check("reset_pwm", int'(o_pwm), 0);
        tick(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            if (i == 0) check("pwm3_first_edge", int'(o_pwm[3]), 1);
            if (i >= 4) for (int k = 0; k < 4; k++) cnt[k] += int'(o_pwm[k]);
        end
        check("idle_sel", int'(o_sel), 0);
        check("duty_ch0", cnt[0], 4);
        check("duty_ch1", cnt[1], 8);
        check("duty_ch2", cnt[2], 12);
        check("duty_ch3", cnt[3], 16);

        // 2: clean held press, advance exactly at edge DC+3
        tick(1'b0, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            tick(1'b1, 1'b0);
            if (i == DC + 2) check("press_before_edge", int'(o_sel), 0);
            if (i == DC + 3) check("press_at_edge", int'(o_sel), 1);
        end
        check("held_no_repeat", int'(o_sel), 1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        check("release_no_step", int'(o_sel), 1);

        // 3: five press/release pairs walk the ring including L4->OFF wrap
        tick(1'b0, 1'b1);
        for (int p = 0; p < 5; p++) begin
            press_release(10);
            check("ring_step", int'(o_sel), exp3[p]);
        end

        // 4: bounce shorter than the debounce window
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        check("bounce_ignored", int'(o_sel), 0);

        // 5: reset at L3 mid-debounce
        for (int p = 0; p < 3; p++) press_release(10);
        check("at_l3", int'(o_sel), 3);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("midreset_sel", int'(o_sel), 0);
        check("midreset_pwm", int'(o_pwm), 0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        check("midreset_no_stray", int'(o_sel), 0);

        // 6: button held through reset release counts as one press
        tick(1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0);
            if (i == DC + 2) check("held_reset_before", int'(o_sel), 0);
            if (i == DC + 3) check("held_reset_edge", int'(o_sel), 1);
        end
        check("held_reset_stays", int'(o_sel), 1);

        // Randomized button activity with occasional resets
        tick(1'b0, 1'b1);
        for (int s = 0; s < 400; s++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            if ($urandom_range(0, 49) == 0) tick(lvl, 1'b1);
            for (int i = 0; i < len; i++) tick(lvl, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
